// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// The FSM state set always includes HALT; it is only reachable when FETCH_HALT_DETECT_EN is defined.
package fetch_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT   = 16'h0000;
    localparam logic [3:0]        HLT_OPCODE_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        PRESENT = 2'd1,
        HALT    = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-fetch-address select: sequential successor or taken-branch target.
// The 16-bit add wraps naturally, so 16'hFFFF is followed by 16'h0000.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_pc_i,
    output logic [ADDR_W-1:0] next_pc_o
);

    logic [ADDR_W-1:0] seq_pc;

    assign seq_pc    = pc_i + ADDR_W'(1);
    assign next_pc_o = br_taken_i ? br_pc_i : seq_pc;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit: FETCH -> PRESENT -> FETCH, with optional HALT.
// Define FETCH_HALT_DETECT_EN to stop fetching after consuming an instruction whose opcode is HLT_OPCODE.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [3:0]        HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               br_ctrl,
    input  logic [ADDR_W-1:0]  br_pc,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               instr_vld,
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               instr_vld_q, instr_vld_d;
    logic [ADDR_W-1:0]  next_pc;

    next_pc_calc u_next_pc_calc (
        .pc_i       (pc_q),
        .br_taken_i (br_ctrl),
        .br_pc_i    (br_pc),
        .next_pc_o  (next_pc)
    );

`ifdef FETCH_HALT_DETECT_EN
    logic halted_q, halted_d;
    logic is_halt;

    assign is_halt = (instr_q[INSTR_W-1:INSTR_W-4] == HLT_OPCODE);
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        instr_vld_d = instr_vld_q;
`ifdef FETCH_HALT_DETECT_EN
        halted_d    = halted_q;
`endif
        unique case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    instr_d     = imem_rdata;
                    pc_d        = fetch_pc_q;
                    instr_vld_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                // Consume cycle: the only place branch information is looked at.
                if (!stall) begin
                    instr_vld_d = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
                    if (is_halt) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        fetch_pc_d = next_pc;
                        state_d    = FETCH;
                    end
`else
                    fetch_pc_d = next_pc;
                    state_d    = FETCH;
`endif
                end
            end
`ifdef FETCH_HALT_DETECT_EN
            HALT: begin
                state_d = HALT;
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            instr_q     <= '0;
            pc_q        <= '0;
            instr_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            instr_vld_q <= instr_vld_d;
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    // imem_addr comes straight from a register that only moves at consume, so it is stable across wait states.
    assign imem_req  = (state_q == FETCH);
    assign imem_addr = fetch_pc_q;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign instr_vld = instr_vld_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the first fetch address after reset.
REQ-002 Parameter HLT_OPCODE, default 4'hF, SHALL be the instr[15:12] value that marks a halt instruction.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 br_ctrl  input  1  SHALL be the branch-taken indication from the execute stage for the presented instr.
REQ-006 br_pc  input  16  SHALL be the branch target from the execute stage.
REQ-007 stall  input  1  SHALL hold the presented instr while high.
REQ-008 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-009 imem_addr  output  16  SHALL be the word address of the request.
REQ-010 imem_ack  input  1  SHALL indicate that imem_rdata is valid this cycle.
REQ-011 imem_rdata  input  16  SHALL be the instruction word returned by memory.
REQ-012 instr  output  16  SHALL be the fetched instruction presented to decode/execute.
REQ-013 pc  output  16  SHALL be the word address of instr.
REQ-014 instr_vld  output  1  SHALL be high while instr/pc are valid.
REQ-015 halted  output  1  SHALL be high once a halt instruction has been consumed.

Function
REQ-016 The FSM SHALL have states FETCH, PRESENT and HALT.
REQ-017 FETCH: imem_req=1, imem_addr=fetch_pc; imem_ack=1 SHALL latch imem_rdata into instr, latch fetch_pc into pc, and move to PRESENT next cycle.
REQ-018 The handshake SHALL tolerate any number of wait cycles, and imem_addr SHALL stay stable until imem_ack.
REQ-019 imem_ack outside FETCH SHALL be ignored.
REQ-020 PRESENT: instr_vld=1, imem_req=0; stall=1 SHALL hold instr, pc and state unchanged.
REQ-021 PRESENT with stall=0 is the consume cycle; br_ctrl and br_pc SHALL be sampled only here and ignored in all other cycles.
REQ-022 At consume, fetch_pc SHALL be br_pc if br_ctrl=1, otherwise pc+1, computed modulo 2^16 (16'hFFFF+1 = 16'h0000), and the FSM SHALL move to FETCH.
REQ-023 At consume, if instr[15:12]==HLT_OPCODE the FSM SHALL enter HALT instead; br_ctrl SHALL be ignored for that instr.
REQ-024 HALT: halted=1, instr_vld=0, imem_req=0; HALT is terminal until rst.
REQ-025 Latency: ack in cycle N SHALL give instr_vld=1 in cycle N+1; an ack in the same cycle as the request is legal (one-cycle fetch).
REQ-026 instr_vld SHALL be registered, with no combinational path from imem_ack, stall or br_ctrl to instr_vld.

Reset
REQ-027 rst=1 at a clock edge SHALL set state=FETCH, fetch_pc=RESET_PC, instr=16'h0000, pc=16'h0000, instr_vld=0, halted=0.
REQ-028 Reset SHALL take priority over ack, stall and br_ctrl.
REQ-029 A fetch in flight SHALL be abandoned; an ack coincident with rst SHALL be discarded.
REQ-030 After rst deasserts, imem_req=1 with imem_addr=RESET_PC in the first cycle.

Configuration
REQ-031 Macro FETCH_HALT_DETECT_EN defined: halt detection SHALL operate as in REQ-023/024.
REQ-032 Macro absent: HALT state and halted logic SHALL be omitted, halted SHALL be tied 0, and HLT_OPCODE instructions SHALL be consumed like any other instruction.

Structure
REQ-033 Package fetch_pkg SHALL hold the FSM state enum (FETCH, PRESENT, HALT), the default HLT_OPCODE and the RESET_PC default constant.
REQ-034 A single sub-module, next_pc_calc (combinational, pc+1 / br_pc select), SHALL be instantiated.
REQ-035 All other logic SHALL be inline in fetch_unit.

Verification
REQ-036 Zero-wait sequential fetch: reset, ack every request, stall=0, br_ctrl=0 -> imem_addr 0000,0001,0002; pc follows one cycle behind.
REQ-037 Wait states and stall: ack delayed 3 cycles -> imem_addr held at 0004 for all 3 cycles; stall=1 for 2 cycles in PRESENT -> instr, pc held, no imem_req.
REQ-038 Branch: pc=0010, br_ctrl=1, br_pc=0080 at consume -> next imem_addr=0080; br_ctrl=1 pulsed during FETCH -> ignored.
REQ-039 Wrap and halt: pc=FFFF consumed -> next imem_addr=0000; instr=F000 consumed with FETCH_HALT_DETECT_EN -> halted=1, no further imem_req; without the macro -> fetch continues at pc+1.
REQ-040 Mid-fetch reset: rst asserted while waiting for ack, ack coincident with rst -> ack discarded, instr_vld=0, next imem_addr=RESET_PC.
